// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and fetch-stage types.
// Imported by the fetch stage and downstream decode.
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_B   = 7'd99;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_JAL = 7'd111;
  localparam logic [6:0] OP_SYS = 7'd115;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single outstanding imem request,
// one-entry instruction buffer and redirect/kill handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = rv32i_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [6:0]  id_op,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        misalign_err
);
  import rv32i_pkg::*;

  fetch_state_e state;
  logic [31:0]  pc;
  logic         kill;
  logic [31:0]  tgt;

  assign tgt         = {redirect_target[31:2], 2'b00};
  assign imem_req    = rst_n & (state == REQ);
  assign imem_addr   = {pc[31:2], 2'b00};
  assign id_op       = id_instr[6:0];
  assign id_pc_plus4 = id_pc + 32'd4;

  // Flag a misaligned redirect target for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid & (|redirect_target[1:0]);
    end
  end

  // Fetch FSM: request, wait for response, hold for decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= 32'd0;
    end else begin
      unique case (state)
        REQ: begin
          if (redirect_valid) pc <= tgt;
          if (imem_gnt) begin
            state <= WAIT;
            kill  <= redirect_valid;
          end
        end
        WAIT: begin
          if (redirect_valid) pc <= tgt;
          if (imem_rvalid) begin
            kill <= 1'b0;
            if (kill || redirect_valid) begin
              state <= REQ;
            end else begin
              id_instr <= imem_rdata;
              id_pc    <= pc;
              id_valid <= 1'b1;
              pc       <= pc + 32'd4;
              state    <= HOLD;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) pc <= tgt;
          if (redirect_valid || id_ready) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            state    <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios
// plus a randomized run against a program-order model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, id_valid, id_ready, misalign_err;
  logic [31:0] redirect_target, id_instr, id_pc, id_pc_plus4;
  logic [6:0]  id_op;

  logic        w_req, w_gnt, w_rvalid, w_rv, w_valid, w_ready, w_mis;
  logic [31:0] w_addr, w_rdata, w_rt, w_instr, w_pc, w_pc4;
  logic [6:0]  w_op;

  int checks = 0;
  int errors = 0;
  int gnt_pct = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit const_data = 1'b0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_op(id_op), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .misalign_err(misalign_err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid),
    .imem_rdata(w_rdata),
    .redirect_valid(w_rv), .redirect_target(w_rt),
    .id_valid(w_valid), .id_ready(w_ready),
    .id_instr(w_instr), .id_op(w_op), .id_pc(w_pc),
    .id_pc_plus4(w_pc4), .misalign_err(w_mis)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h8) return 32'hDEAD_BEEF;
    return {a[26:2] ^ 25'h15A_5A5A, 7'h33};
  endfunction

  // Instruction memory: random grant, latency lat_min..lat_max.
  initial begin
    logic        granted;
    logic        outst;
    logic [31:0] gaddr, qaddr;
    int          cnt;
    granted = 1'b0; outst = 1'b0; cnt = 0;
    gaddr = '0; qaddr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        granted = 1'b0; outst = 1'b0;
        imem_rvalid = 1'b0; imem_gnt = 1'b0;
      end else begin
        if (imem_rvalid) begin
          imem_rvalid = 1'b0;
          outst = 1'b0;
        end
        if (granted) begin
          outst = 1'b1;
          qaddr = gaddr;
          cnt = int'($urandom_range(lat_max, lat_min));
          granted = 1'b0;
        end
        imem_rdata = $urandom;
        if (outst) begin
          cnt = cnt - 1;
          if (cnt <= 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = const_data ? 32'h0050_0093
                                    : mem_fn(qaddr);
          end
        end
        imem_gnt = int'($urandom_range(99, 0)) < gnt_pct;
        granted = imem_req && imem_gnt;
        gaddr = imem_addr;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    gnt_pct = 0; id_ready = 1'b0; redirect_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", id_valid); end
    checks++; if (id_instr !== NOP) begin errors++; $display("FAIL rst_instr got %h want %h", id_instr, NOP); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", id_pc); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_mis got %b want 0", misalign_err); end
    checks++; if (id_op !== 7'h13) begin errors++; $display("FAIL rst_op got %h want 13", id_op); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rel_addr got %h want 0", imem_addr); end
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rst_fill timeout got %b want 1", id_valid); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", id_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_req got %b want 0", imem_req); end
    checks++; if (id_instr !== NOP) begin errors++; $display("FAIL async_instr got %h want %h", id_instr, NOP); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL async_rel addr %h req %b want 0/1", imem_addr, imem_req); end
  endtask

  task automatic test_basic();
    logic [31:0] addrs [3];
    int          at [3];
    int          na;
    bit          seen;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    const_data = 1'b1; id_ready = 1'b1;
    do_reset();
    na = 0; seen = 1'b0;
    for (int i = 0; i < 30 && na < 3; i++) begin
      @(negedge clk);
      if (imem_req) begin addrs[na] = imem_addr; at[na] = i; na++; end
      if (id_valid && !seen) begin
        seen = 1'b1;
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL basic_pc got %h want 0", id_pc); end
        checks++; if (id_op !== 7'h13) begin errors++; $display("FAIL basic_op got %h want 13", id_op); end
        checks++; if (id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL basic_pc4 got %h want 4", id_pc_plus4); end
        checks++; if (id_instr !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got %h want 00500093", id_instr); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL basic_valid timeout got 0 want 1"); end
    checks++; if (na != 3) begin errors++; $display("FAIL basic_nreq got %0d want 3", na); end
    for (int k = 0; k < na; k++) begin
      checks++; if (addrs[k] !== 32'(4 * k)) begin errors++; $display("FAIL basic_addr%0d got %h want %h", k, addrs[k], 4 * k); end
      if (k > 0) begin
        checks++; if (at[k] - at[k-1] != 3) begin errors++; $display("FAIL basic_gap%0d got %0d want 3", k, at[k] - at[k-1]); end
      end
    end
    const_data = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] i0, p0;
    int          n;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    id_ready = 1'b0;
    do_reset();
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    i0 = id_instr; p0 = id_pc;
    checks++; if (p0 !== 32'h0 || i0 !== mem_fn(32'h0)) begin errors++; $display("FAIL stall_load got %h/%h want 0/%h", p0, i0, mem_fn(0)); end
    repeat (5) begin
      @(negedge clk);
      checks++; if (id_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold valid %b req %b want 1/0", id_valid, imem_req); end
      checks++; if (id_instr !== i0 || id_pc !== p0) begin errors++; $display("FAIL stall_stable got %h/%h want %h/%h", id_instr, id_pc, i0, p0); end
    end
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL stall_next req %b addr %h want 1/4", imem_req, imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stall_drop got %b want 0", id_valid); end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] first;
    bit          got_first, bad, done;
    int          n;
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    id_ready = 1'b1;
    do_reset();
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 40) begin @(negedge clk); n++; end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL rw_reach addr got %h want 8", imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL rw_wait req %b valid %b want 0/0", imem_req, id_valid); end
    redirect_valid = 1'b1; redirect_target = 32'h100;
    got_first = 1'b0; bad = 1'b0; done = 1'b0; first = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      if (id_instr === 32'hDEAD_BEEF) bad = 1'b1;
      if (imem_req && !got_first) begin got_first = 1'b1; first = imem_addr; end
      if (id_valid) done = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rw_kill got DEADBEEF want never"); end
    checks++; if (first !== 32'h100) begin errors++; $display("FAIL rw_addr got %h want 100", first); end
    checks++; if (id_pc !== 32'h100 || id_instr !== mem_fn(32'h100)) begin errors++; $display("FAIL rw_deliver got %h/%h want 100/%h", id_pc, id_instr, mem_fn(32'h100)); end
  endtask

  task automatic test_redirect_hold();
    int n;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    id_ready = 1'b0;
    do_reset();
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rh_valid got %b want 0", id_valid); end
    checks++; if (id_instr !== NOP || id_op !== 7'h13) begin errors++; $display("FAIL rh_nop got %h want %h", id_instr, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL rh_addr req %b addr %h want 1/40", imem_req, imem_addr); end
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (id_pc !== 32'h40) begin errors++; $display("FAIL rh_pc got %h want 40", id_pc); end
  endtask

  task automatic test_misalign();
    int n;
    gnt_pct = 0; id_ready = 1'b1;
    do_reset();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_target = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b want 1", misalign_err); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL mis_addr req %b addr %h want 1/100", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", misalign_err); end
    redirect_valid = 1'b1; redirect_target = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_aligned got %b want 0", misalign_err); end
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL mis_addr2 got %h want 200", imem_addr); end
    gnt_pct = 100; lat_min = 1; lat_max = 1; id_ready = 1'b0;
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (id_pc !== 32'h200) begin errors++; $display("FAIL mis_fetch got %h want 200", id_pc); end
  endtask

  task automatic test_wrap();
    gnt_pct = 0;
    do_reset();
    @(negedge clk);
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req req %b addr %h want 1/fffffffc", w_req, w_addr); end
    w_gnt = 1'b1;
    @(negedge clk);
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h0000_0013;
    @(negedge clk);
    w_rvalid = 1'b0;
    checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc valid %b pc %h want 1/fffffffc", w_valid, w_pc); end
    checks++; if (w_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", w_pc4); end
    w_ready = 1'b1;
    @(negedge clk);
    w_ready = 1'b0;
    checks++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin errors++; $display("FAIL wrap_next req %b addr %h want 1/0", w_req, w_addr); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, hold_pc;
    bit          exp_mis, prev_hold;
    int          consumed;
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    id_ready = 1'b0;
    do_reset();
    exp_pc = 32'h0; hold_pc = '0;
    exp_mis = 1'b0; prev_hold = 1'b0; consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++; if (misalign_err !== exp_mis) begin errors++; $display("FAIL rnd_mis @%0d got %b want %b", i, misalign_err, exp_mis); end
      checks++; if (imem_addr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_align @%0d got %h want xxxxxxx0", i, imem_addr); end
      checks++; if (id_op !== id_instr[6:0]) begin errors++; $display("FAIL rnd_op @%0d got %h want %h", i, id_op, id_instr[6:0]); end
      if (prev_hold) begin
        checks++; if (id_valid !== 1'b1 || id_pc !== hold_pc) begin errors++; $display("FAIL rnd_hold @%0d got %b/%h want 1/%h", i, id_valid, id_pc, hold_pc); end
      end
      if (id_valid) begin
        checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc @%0d got %h want %h", i, id_pc, exp_pc); end
        checks++; if (id_instr !== mem_fn(id_pc)) begin errors++; $display("FAIL rnd_instr @%0d got %h want %h", i, id_instr, mem_fn(id_pc)); end
        checks++; if (id_pc_plus4 !== id_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4 @%0d got %h want %h", i, id_pc_plus4, id_pc + 32'd4); end
      end else begin
        checks++; if (id_instr !== NOP) begin errors++; $display("FAIL rnd_nop @%0d got %h want %h", i, id_instr, NOP); end
      end
      redirect_valid = int'($urandom_range(99, 0)) < 4;
      redirect_target = $urandom;
      id_ready = int'($urandom_range(99, 0)) < 70;
      exp_mis = redirect_valid && (redirect_target[1:0] != 2'b00);
      prev_hold = id_valid && !id_ready && !redirect_valid;
      hold_pc = id_pc;
      if (redirect_valid) begin
        exp_pc = redirect_target & 32'hFFFF_FFFC;
      end else if (id_valid && id_ready) begin
        exp_pc = id_pc + 32'd4;
        consumed++;
      end
    end
    redirect_valid = 1'b0;
    checks++; if (consumed < 200) begin errors++; $display("FAIL rnd_progress got %0d want >=200", consumed); end
  endtask

  initial begin
    rst_n = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
    w_rv = 1'b0; w_rt = '0; w_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_misalign();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
